// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: state
// encodings, default sizes, the hard-wired zero register address and an
// index-width helper.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_NREQ = 3;
  localparam int unsigned DEF_AW   = 5;
  localparam int unsigned DEF_DW   = 32;

  // Writes to this address are acknowledged but never reach the regfile.
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // Width of a requester index; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req    - request vector
//   ptr    - highest-priority index for this pick
//   mask   - only requests with a set mask bit take part
//   winner - one-hot winner (zero when nothing valid)
//   index  - winner index
//   valid  - at least one masked request present
module rr_picker
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            valid
);

  logic [NREQ-1:0] masked;
  logic [IW-1:0]   cand;

  // (p + k) mod NREQ, valid because both operands are below NREQ.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= int'(NREQ)) s = s - int'(NREQ);
    return IW'(s);
  endfunction

  // Scan from ptr upward; the first masked request wins.
  always_comb begin
    masked = req & mask;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = wrap(ptr, k);
      if (!valid && masked[cand]) begin
        index = cand;
        valid = 1'b1;
      end
    end
    winner = valid ? (NREQ'(1) << index) : '0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port (we3/a3/wd3) among
// NREQ requesters, with an optional per-grant lock for bursts.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   req, req_lock    - per-requester request and lock
//   req_addr         - packed addresses, requester i at [i*AW +: AW]
//   req_data         - packed data, requester i at [i*DW +: DW]
//   gnt              - one-hot, one-cycle grant per accepted write
//   we3, a3, wd3     - regfile write port
//   owner, locked    - last/holding requester and lock status
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  parameter  int unsigned AW   = DEF_AW,
  parameter  int unsigned DW   = DEF_DW,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic             we3,
  output logic [AW-1:0]      a3,
  output logic [DW-1:0]      wd3,
  output logic [IW-1:0]      owner,
  output logic             locked
);

  state_e          state_q, state_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic            we3_q, we3_n;
  logic [AW-1:0]   a3_q, a3_n;
  logic [DW-1:0]   wd3_q, wd3_n;
  logic [IW-1:0]   owner_q, owner_n;
  logic            locked_q, locked_n;
  logic [IW-1:0]   ptr_q, ptr_n;

  logic [NREQ-1:0] pick_mask;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            do_grant;

  // Everyone competes when idle, only the owner while held, nobody during GRANT.
  always_comb begin
    case (state_q)
      S_GRANT: pick_mask = '0;
      S_HOLD:  pick_mask = NREQ'(1) << owner_q;
      default: pick_mask = '1;
    endcase
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .mask   (pick_mask),
    .winner (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  // Payload of the winning requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state_q;
    gnt_n    = '0;
    we3_n    = 1'b0;
    a3_n     = a3_q;
    wd3_n    = wd3_q;
    owner_n  = owner_q;
    locked_n = locked_q;
    ptr_n    = ptr_q;
    do_grant = 1'b0;

    case (state_q)
      S_GRANT: state_n = locked_q ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (pick_valid) begin
          do_grant = 1'b1;
        end else if (!req_lock[owner_q]) begin
          locked_n = 1'b0;
          state_n  = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        if (pick_valid) begin
          do_grant = 1'b1;
          ptr_n    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        end
      end
    endcase

    if (do_grant) begin
      state_n  = S_GRANT;
      gnt_n    = pick_onehot;
      we3_n    = (sel_addr != AW'(ZERO_REG));
      a3_n     = sel_addr;
      wd3_n    = sel_data;
      owner_n  = pick_idx;
      locked_n = req_lock[pick_idx];
    end
  end

  // State and output registers; reset also kills an in-flight write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      we3_q    <= we3_n;
      a3_q     <= a3_n;
      wd3_q    <= wd3_n;
      owner_q  <= owner_n;
      locked_q <= locked_n;
      ptr_q    <= ptr_n;
    end
  end

  assign gnt    = gnt_q;
  assign we3    = we3_q;
  assign a3     = a3_q;
  assign wd3    = wd3_q;
  assign owner  = owner_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 2;
  localparam int          NCYC = 3000;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req, req_lock, gnt;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 we3;
  logic [AW-1:0]        a3;
  logic [DW-1:0]        wd3;
  logic [IW-1:0]        owner;
  logic                 locked;

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .we3      (we3),
    .a3       (a3),
    .wd3      (wd3),
    .owner    (owner),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  // Simple regfile fed by the write port; address 0 is only protected by we3.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (we3) rf[a3] <= wd3;

  typedef struct {
    int            cyc;
    logic [NREQ-1:0] gnt;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    int            owner;
    logic          locked;
  } ev_t;

  ev_t  evq[$];
  logic lockq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model: port phase 0 free, 1 granting, 2 held by m_holder.
  int              m_phase = 0;
  int              m_holder = 0;
  int              m_next = 0;
  logic            m_locked = 1'b0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [DW-1:0]   mrf [32] = '{default: '0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Predict the cycle after the coming edge from the inputs now applied.
  task automatic model_step();
    ev_t e;
    int  w;
    w = -1;
    if (m_phase == 1) begin
      m_gnt   = '0;
      m_phase = m_locked ? 2 : 0;
    end else begin
      if (m_phase == 0) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          int c;
          c = (m_next + k) % int'(NREQ);
          if (w < 0 && req[c]) w = c;
        end
      end else if (req[m_holder]) begin
        w = m_holder;
      end
      if (w >= 0) begin
        e.cyc    = cyc + 1;
        e.gnt    = '0;
        e.gnt[w] = 1'b1;
        e.a3     = req_addr[w*AW +: AW];
        e.wd3    = req_data[w*DW +: DW];
        e.we3    = (e.a3 != 0);
        e.owner  = w;
        e.locked = req_lock[w];
        if (m_phase == 0) m_next = (w + 1) % int'(NREQ);
        m_holder = w;
        m_locked = req_lock[w];
        m_gnt    = e.gnt;
        m_phase  = 1;
        if (e.we3) mrf[e.a3] = e.wd3;
        evq.push_back(e);
      end else begin
        m_gnt = '0;
        if (m_phase == 2 && !req_lock[m_holder]) begin
          m_locked = 1'b0;
          m_phase  = 0;
        end
      end
    end
    lockq.push_back(m_locked);
  endtask

  // Requesters hold a request until granted, then drop it or issue a new one.
  task automatic update_reqs();
    for (int i = 0; i < int'(NREQ); i++) begin
      bit start;
      if (m_gnt[i]) start = ($urandom_range(0, 1) == 0);
      else if (!req[i]) start = ($urandom_range(0, 9) < 3);
      else continue;
      if (start) begin
        req[i]                 = 1'b1;
        req_addr[i*AW +: AW]   = AW'($urandom_range(0, 7));
        req_data[i*DW +: DW]   = $urandom();
        req_lock[i]            = ($urandom_range(0, 3) == 0);
      end else begin
        req[i]      = 1'b0;
        req_lock[i] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  // Monitor: per-cycle lock status plus grant events from the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        cyc++;
        checks++;
        if (lockq.size() == 0) begin
          failures++;
          $display("FAIL lock_queue_empty cyc=%0d", cyc);
        end else begin
          logic el;
          el = lockq.pop_front();
          if (locked !== el) begin
            failures++;
            $display("FAIL locked cyc=%0d actual=%b required=%b", cyc, locked, el);
          end
        end
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL missed_grant cyc=%0d required_gnt=%b", evq[0].cyc, evq[0].gnt);
          void'(evq.pop_front());
        end
        if (gnt != '0) begin
          checks++;
          if (evq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant cyc=%0d actual gnt=%b", cyc, gnt);
          end else begin
            e = evq.pop_front();
            if (e.cyc != cyc || e.gnt !== gnt || e.we3 !== we3 || e.a3 !== a3 ||
                e.wd3 !== wd3 || e.owner != int'(owner) || e.locked !== locked) begin
              failures++;
              $display("FAIL grant_event actual cyc=%0d gnt=%b we3=%b a3=%h wd3=%h owner=%0d locked=%b required cyc=%0d gnt=%b we3=%b a3=%h wd3=%h owner=%0d locked=%b",
                       cyc, gnt, we3, a3, wd3, owner, locked,
                       e.cyc, e.gnt, e.we3, e.a3, e.wd3, e.owner, e.locked);
            end
          end
        end else begin
          checks++;
          if (we3 !== 1'b0) begin
            failures++;
            $display("FAIL we3_without_gnt cyc=%0d actual=%b required=0", cyc, we3);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [DW-1:0] d9;
    reset_n  = 1'b0;
    req      = '1;
    req_lock = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = 32'h1000_0000 + i;
    end

    // Reset held with all requesters active: port stays quiet.
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_we3", 64'(we3), 64'd0);
      chk("rst_a3", 64'(a3), 64'd0);
      chk("rst_wd3", 64'(wd3), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
    end

    // Release; first grant must go to requester 0 one cycle later.
    reset_n = 1'b1;
    mon_en  = 1'b1;
    model_step();
    repeat (NCYC) begin
      @(negedge clk);
      update_reqs();
      model_step();
    end

    // Drain: withdraw everything so holds release and writes land.
    repeat (6) begin
      @(negedge clk);
      req      = '0;
      req_lock = '0;
      model_step();
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("events_left", 64'(evq.size()), 64'd0);
    chk("lock_left", 64'(lockq.size()), 64'd0);
    for (int r = 0; r < 32; r++) chk($sformatf("rf[%0d]", r), 64'(rf[r]), 64'(mrf[r]));

    // Reset during the grant cycle aborts the write asynchronously.
    @(negedge clk);
    d9 = ~mrf[9];
    req[1] = 1'b1;
    req_addr[1*AW +: AW] = 5'd9;
    req_data[1*DW +: DW] = d9;
    @(posedge clk);
    #1;
    chk("mid_gnt", 64'(gnt), 64'b010);
    chk("mid_we3", 64'(we3), 64'd1);
    chk("mid_a3", 64'(a3), 64'd9);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_gnt", 64'(gnt), 64'd0);
    chk("abort_we3", 64'(we3), 64'd0);
    chk("abort_owner", 64'(owner), 64'd0);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #1;
    chk("abort_rf9", 64'(rf[9]), 64'(mrf[9]));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) among NREQ requesters, e.g. multicycle writeback, a program/debug loader and an exception-save unit.
- Round-robin arbitration with a registered request/grant handshake.
- Optional lock lets one requester own the port for a burst.
- Sits between the requesters and regfile; regfile read ports are untouched.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request; held until granted.
- req_lock  input  NREQ  per-requester lock; sampled with req at grant time.
- req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- gnt  output  NREQ  one-hot grant, high exactly one cycle per accepted write.
- we3  output  1  regfile write enable.
- a3  output  AW  regfile write address.
- wd3  output  DW  regfile write data.
- owner  output  clog2(NREQ)  index of last/holding granted requester.
- locked  output  1  high while the port is held by owner.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (reset_n); clk and reset_n are the only clock/reset ports.
- Reset values: gnt=0, we3=0, a3=0, wd3=0, owner=0, locked=0, state=IDLE, rr pointer=0 (requester 0 highest priority).
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, GRANT, HOLD (2-bit encoding).
- IDLE:
  - If any req, pick winner w by round-robin starting at the pointer.
  - Next edge: state=GRANT, gnt[w]=1, we3=1, a3/wd3 = w's addr/data, owner=w.
  - locked = req_lock[w].
  - Pointer becomes (w+1) mod NREQ.
  - No req: stay IDLE, outputs idle (gnt=0, we3=0).
- GRANT (one cycle; regfile writes at the end of it):
  - Requester w sees gnt[w] and must drop or change req by the next edge.
  - The arbiter ignores all req during GRANT, so no double grant.
  - Next: if locked, go to HOLD, else IDLE.
  - gnt and we3 return to 0.
- Latency and throughput: req asserted in cycle t gives gnt/we3 in cycle t+1 if uncontended. Max throughput is 1 write per 2 cycles.
- HOLD:
  - Only req[owner] is considered; other requests wait (starvation bounded by owner's lock).
  - If req[owner]: grant as in IDLE (same owner, locked re-sampled from req_lock[owner]). Pointer unchanged while locked.
  - Else if !req_lock[owner]: locked=0, go to IDLE.
  - Else stay HOLD.
- Address 0 (hard-wired zero register): the write is acknowledged (gnt pulses) but we3 stays 0; a3/wd3 still show the values.
- Simultaneous requests: exactly one gnt bit; round-robin guarantees each of NREQ steady requesters is served within NREQ grants.
- Reset mid-operation: an in-flight GRANT is aborted immediately (we3 and gnt forced to 0 asynchronously). The write is lost; the requester must re-request after reset_n rises.
- X or invalid state decodes to IDLE.

Decomposition:
- Shared include regfile_defs:
  - State encodings S_IDLE=2'd0, S_GRANT=2'd1, S_HOLD=2'd2.
  - Default AW/DW/NREQ.
  - ZERO_REG=5'd0.
- One sub-module: rr_picker. Combinational: inputs req vector, pointer, mask; outputs one-hot winner, index, valid. Reusable for future read-port arbitration.

Test Plan:
- Reset: hold reset_n=0 with req=3'b111 -> gnt=0, we3=0, a3=0, wd3=0 throughout. Release -> first gnt=3'b001 one cycle later.
- Single write: req[1]=1, addr=5'h1, data=32'hABCD_EFAB -> next cycle gnt=3'b010, we3=1, a3=1, wd3=32'hABCD_EFAB for one cycle. Regfile rd1 at a1=1 reads ABCDEFAB afterwards.
- Round-robin: req=3'b111 held continuously -> grant order 001,010,100,001, each GRANT separated by one idle cycle.
- Zero register: req[0], addr=0, data=32'hCCCC_CCCC -> gnt[0]=1, we3=0; regfile rd at a1=0 stays 0.
- Lock burst: req[2] with req_lock[2]=1 writing regs 3,4,5 while req[0] is pending -> three grants to requester 2, locked=1 throughout. After lock drops: IDLE, then gnt=3'b001.
- Reset mid-GRANT: assert reset_n=0 during the gnt cycle -> we3 and gnt fall without a clock edge; target register is unchanged.
